bus_master_tx: RTL and testbench
================================

Name: bus_master_tx

Overview:
- Upstream serial-bus transmitter that drives a slave's rx line.
- Buffers bytes from the local host in a small FIFO and waits for the shared bus to be free (bus_busy low).
- Serialises each byte at one bit per clk cycle: start bit 0, DATA_W data bits LSB first, stop bit 1.
- After each frame, waits for the slave to acknowledge by pulling its tx line (our ack_in) low.

Parameters:
- DATA_W, 8, payload bits per frame.
- FIFO_DEPTH, 4, host-side byte buffer entries; must be a power of 2 and ≥ 2.
- ACK_TIMEOUT, 16, maximum cycles to wait for ack after the stop bit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  byte from host.
- in_valid  in  1  host byte valid.
- in_ready  out  1  FIFO can accept; equals !fifo_full.
- bus_busy  in  1  bus owned by another agent; blocks only the start of a frame.
- tx  out  1  serial line to slave rx; idle high; registered.
- ack_in  in  1  slave tx line; idle high; low = ack.
- active  out  1  high from start bit through end of ACK_WAIT.
- frame_done  out  1  1-cycle pulse when a frame's ack phase ends.
- ack_err  out  1  1-cycle pulse, coincident with frame_done, on ack timeout.

Behaviour:
- Reset values (applied asynchronously): tx=1, active=0, frame_done=0, ack_err=0, FIFO empty, in_ready=1, state=IDLE, counters 0.
- Push: occurs on in_valid && in_ready. There is no bypass; a byte pushed into an empty FIFO is visible to the FSM the next cycle.
- IDLE:
  - If FIFO non-empty && !bus_busy: pop the byte into a shift register, set tx=0, active=1, go to START.
  - The start bit therefore appears 1 cycle after the qualifying cycle.
- START (1 cycle) → DATA.
- DATA:
  - Shift out LSB first for DATA_W cycles.
  - A bit counter counts 0..DATA_W-1; on the last bit go to STOP (or PARITY if enabled).
- STOP: tx=1 for 1 cycle → ACK_WAIT with the ack counter cleared.
- ACK_WAIT:
  - Sample ack_in each cycle, starting the cycle after STOP.
  - If ack_in=0: pulse frame_done and go to IDLE with active=0.
  - If the counter reaches ACK_TIMEOUT without ack: pulse frame_done and ack_err together, go to IDLE.
- Frame length: DATA_W+2 cycles on tx (+1 with parity).
- Back-to-back frames: the earliest next start bit is 1 cycle after frame_done (one IDLE cycle minimum).
- bus_busy changes after START are ignored; the frame always completes.
- Push while FIFO full: refused (in_ready=0). A simultaneous push and pop when full is also refused, because in_ready is derived from the registered full flag.
- Reset mid-frame: tx returns to 1 immediately, the FIFO is flushed, and no frame_done is issued.

Optional Feature:
- Macro: BUS_MASTER_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and drives 1 cycle of even parity (XOR of the data bits).
  - Frame length becomes DATA_W+3.
- Undefined: no PARITY state exists and the frame goes directly from DATA to STOP.

Decomposition:
- Package bus_pkg:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP, ACK_WAIT};
  - constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - shared DATA_W default.
- Sub-module bus_tx_fifo:
  - parameterised synchronous FIFO (DATA_W, FIFO_DEPTH);
  - push/pop/full/empty, asynchronous active-high reset on clk/rst.
- FSM, shift register, and counters live in bus_master_tx.

Test Plan:
1. Push 0xA5 with bus_busy=0; slave drops ack_in 2 cycles after stop → tx = 0,1,0,1,0,0,1,0,1,1; active high throughout; frame_done pulse with ack_err=0 exactly 2 cycles after the stop bit.
2. Hold bus_busy=1 for 5 cycles with 0x3C queued → tx stays 1 and active=0; start bit appears 1 cycle after the cycle bus_busy is sampled low.
3. With bus_busy=1, push 5 bytes 0x01..0x05 → 4 accepted, in_ready=0 on the 5th; release busy → frames 0x01..0x04 sent in order, each separated by ≥1 idle-high cycle.
4. ack_in held 1 with ACK_TIMEOUT=16 → frame_done and ack_err pulse together 16 cycles after the stop bit; next queued byte then starts normally.
5. Assert rst during data bit 3 of 0xFF → tx=1, active=0, in_ready=1 immediately; no frame_done; a byte pushed after release transmits a clean full frame.
6. With BUS_MASTER_TX_PARITY_EN, send 0x07 → parity bit 1 between bit 7 and stop; frame is 11 cycles long. With 0x03 → parity bit 0.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, line levels and default width for the
// bus master transmitter slice.
package bus_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ACK_WAIT
  } tx_state_t;

endpackage

// File: rtl/bus_tx_fifo.sv
// bus_tx_fifo: small synchronous FIFO buffering host bytes ahead of the
// serialiser. Depth must be a power of two so the pointers wrap on their own.
// Full and empty are registered so the host-side ready never depends on the
// same-cycle pop decision.
module bus_tx_fifo
  import bus_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              do_push;
  logic              do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Next occupancy, used to keep the registered full/empty flags in step.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Byte storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/bus_master_tx.sv
// bus_master_tx: buffers host bytes, waits for a free bus, then sends each
// byte as start bit, LSB-first data, optional even parity and stop bit, and
// finally waits a bounded time for the slave to pull ack_in low.
// Optional feature macro: BUS_MASTER_TX_PARITY_EN adds a parity bit after
// the data bits.
module bus_master_tx
  import bus_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bus_busy,
  output logic              tx,
  input  logic              ack_in,
  output logic              active,
  output logic              frame_done,
  output logic              ack_err
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [ACK_W-1:0] LAST_ACK = ACK_W'(ACK_TIMEOUT - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ACK_W-1:0]  ack_cnt;
`ifdef BUS_MASTER_TX_PARITY_EN
  logic              parity_bit;
`endif

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              push;
  logic              pop;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // A frame may only begin from IDLE; once started, bus_busy is ignored.
  assign pop      = (state == IDLE) && !fifo_empty && !bus_busy;

  bus_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame sequencer: drives the registered tx line and the status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= IDLE_LEVEL;
      active     <= 1'b0;
      frame_done <= 1'b0;
      ack_err    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      ack_cnt    <= '0;
`ifdef BUS_MASTER_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      ack_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg  <= fifo_dout;
            tx     <= START_BIT;
            active <= 1'b1;
            state  <= START;
`ifdef BUS_MASTER_TX_PARITY_EN
            parity_bit <= ^fifo_dout;
`endif
          end
        end
        START: begin
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
`ifdef BUS_MASTER_TX_PARITY_EN
            tx    <= parity_bit;
            state <= PARITY;
`else
            tx    <= STOP_BIT;
            state <= STOP;
`endif
          end else begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
`ifdef BUS_MASTER_TX_PARITY_EN
        PARITY: begin
          tx    <= STOP_BIT;
          state <= STOP;
        end
`endif
        STOP: begin
          tx      <= IDLE_LEVEL;
          ack_cnt <= '0;
          state   <= ACK_WAIT;
        end
        ACK_WAIT: begin
          if (!ack_in) begin
            frame_done <= 1'b1;
            active     <= 1'b0;
            state      <= IDLE;
          end else if (ack_cnt == LAST_ACK) begin
            frame_done <= 1'b1;
            ack_err    <= 1'b1;
            active     <= 1'b0;
            state      <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + ACK_W'(1);
          end
        end
        default: begin
          tx     <= IDLE_LEVEL;
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_tx.sv
// tb_bus_master_tx: self-checking bench for bus_master_tx.
// Inputs change and outputs are sampled on the falling clock edge. Timing
// language used below: the stop bit occupies cycle S; "ack after N cycles"
// means ack_in is low in cycle S+N, and frame_done is expected in the cycle
// after the ack (or after the ACK_TIMEOUT-th waiting cycle on a timeout).
`timescale 1ns/1ps
module tb_bus_master_tx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
`ifdef BUS_MASTER_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = DW + 2 + PAR;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [DW-1:0] in_data  = '0;
  logic          in_valid = 1'b0;
  logic          bus_busy = 1'b0;
  logic          ack_in   = 1'b1;
  logic          in_ready;
  logic          tx;
  logic          active;
  logic          frame_done;
  logic          ack_err;

  int nAssert = 0;
  int nFail   = 0;

  // Bytes the host has successfully handed over and not yet seen on the line.
  logic [DW-1:0] modelQ[$];

  typedef struct {
    logic [DW-1:0] data;
    int            ackDelay;
    int            expOffset;
    logic          expErr;
  } vec_t;

  vec_t vecs[5];

  bus_master_tx #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bus_busy   (bus_busy),
    .tx         (tx),
    .ack_in     (ack_in),
    .active     (active),
    .frame_done (frame_done),
    .ack_err    (ack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Full line image of a frame: bit 0 is the start bit, then data LSB
  // first, then optional even parity, then the stop bit.
  function automatic logic [63:0] frameWord(input logic [DW-1:0] d);
    logic [63:0] w;
    w = 64'(d) << 1;
    if (PAR != 0) w = w | (64'($countones(d) % 2) << (DW + 1));
    w = w | (64'(1) << (DW + 1 + PAR));
    return w;
  endfunction

  function automatic int ackOffset(input int ackDelay);
    return (ackDelay <= TMO) ? ackDelay : TMO;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nAssert++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                               input logic busy);
    in_valid = valid;
    in_data  = data;
    bus_busy = busy;
  endtask

  // Offer one byte during the current cycle; ends on the next falling edge.
  task automatic pushByte(input logic [DW-1:0] d, input logic busy, input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, modelQ.size() < DEPTH);
    applyStimulus(1'b1, d, busy);
    if (modelQ.size() < DEPTH) modelQ.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Follow one frame and its ack phase, checking every cycle.
  task automatic runFrame(input logic [DW-1:0] d, input int ackDelay,
                          input int expOffset, input logic expErr,
                          input bit jitter, input string tag,
                          output int waited, output logic [63:0] seen);
    logic [63:0] word;
    word   = frameWord(d);
    seen   = '0;
    waited = 0;
    while (tx !== 1'b0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      checkOutput({tag, "_start_timeout"}, tx, 0);
      return;
    end
    for (int i = 0; i < FLEN; i++) begin
      if (i > 0) @(negedge clk);
      seen[i] = tx;
      checkOutput($sformatf("%s_bit%0d", tag, i), tx, (word >> i) & 64'd1);
      checkOutput($sformatf("%s_active%0d", tag, i), {active, frame_done}, 2'b10);
      if (jitter) bus_busy = 1'($urandom_range(0, 1));
    end
    for (int j = 1; j <= expOffset + 1; j++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_done_c%0d", tag, j), frame_done, j == expOffset + 1);
      checkOutput($sformatf("%s_err_c%0d", tag, j), ack_err, (j == expOffset + 1) && expErr);
      checkOutput($sformatf("%s_act_c%0d", tag, j), active, j <= expOffset);
      if (j == expOffset + 1) begin
        checkOutput({tag, "_idle_after"}, tx, 1);
        ack_in   = 1'b1;
        bus_busy = 1'b0;
      end else begin
        ack_in = (j >= ackDelay) ? 1'b0 : 1'b1;
        if (jitter) bus_busy = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    int          waited;
    logic [63:0] seen;
    logic [DW-1:0] d;
    int          ad;
    int          m;

    vecs[0] = '{8'hA5, 2, 2, 1'b0};
    vecs[1] = '{8'h00, 1, 1, 1'b0};
    vecs[2] = '{8'hFF, 16, 16, 1'b0};
    vecs[3] = '{8'h81, 17, 16, 1'b1};
    vecs[4] = '{8'h3C, 40, 16, 1'b1};

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_active", active, 0);
    checkOutput("reset_done", frame_done, 0);
    checkOutput("reset_err", ack_err, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames, starting with 0xA5 acked two cycles after stop.
    for (int v = 0; v < 5; v++) begin
      pushByte(vecs[v].data, 1'b0, $sformatf("vec%0d_push", v));
      d = modelQ.pop_front();
      runFrame(d, vecs[v].ackDelay, vecs[v].expOffset, vecs[v].expErr, 1'b0,
               $sformatf("vec%0d", v), waited, seen);
      checkOutput($sformatf("vec%0d_latency", v), waited, 1);
    end

    // Bus held busy with 0x3C queued, then released.
    pushByte(8'h3C, 1'b1, "busy_push");
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("busy_hold%0d", k), {tx, active}, 2'b10);
      if (k == 4) bus_busy = 1'b0;
      else @(negedge clk);
    end
    d = modelQ.pop_front();
    runFrame(d, 1, 1, 1'b0, 1'b0, "busy_frame", waited, seen);
    checkOutput("busy_release_latency", waited, 1);

    // Overfill while busy; the fifth offer coincides with the first pop.
    for (int i = 1; i <= 5; i++) begin
      pushByte(8'(i), (i == 5) ? 1'b0 : 1'b1, $sformatf("fill%0d", i));
    end
    checkOutput("fill_model_count", modelQ.size(), DEPTH);
    while (modelQ.size() > 0) begin
      d = modelQ.pop_front();
      runFrame(d, 1, 1, 1'b0, 1'b0, $sformatf("fill_frame_%0h", d), waited, seen);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checkOutput($sformatf("fill_drained%0d", k), {tx, active}, 2'b10);
    end

    // Ack timeout followed by a normally acked queued byte.
    pushByte(8'h5A, 1'b1, "tmo_push0");
    pushByte(8'hC3, 1'b1, "tmo_push1");
    bus_busy = 1'b0;
    d = modelQ.pop_front();
    runFrame(d, 100, ackOffset(100), 1'b1, 1'b0, "tmo_frame", waited, seen);
    d = modelQ.pop_front();
    runFrame(d, 3, ackOffset(3), 1'b0, 1'b0, "tmo_next", waited, seen);
    checkOutput("tmo_next_latency", waited, 1);

    // Reset during data bit 3 of 0xFF with a full FIFO behind it.
    pushByte(8'hFF, 1'b1, "rst_push0");
    pushByte(8'h11, 1'b1, "rst_push1");
    pushByte(8'h22, 1'b1, "rst_push2");
    pushByte(8'h33, 1'b1, "rst_push3");
    bus_busy = 1'b0;
    @(negedge clk);
    checkOutput("rst_start", tx, 0);
    void'(modelQ.pop_front());
    pushByte(8'h44, 1'b0, "rst_push4");
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_active", active, 1);
    checkOutput("rst_pre_in_ready", in_ready, modelQ.size() < DEPTH);
    rst = 1'b1;
    #1;
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_done", frame_done, 0);
    modelQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_flushed%0d", k), {tx, active, frame_done}, 3'b100);
    end
    pushByte(8'h96, 1'b0, "rst_after_push");
    d = modelQ.pop_front();
    runFrame(d, 1, 1, 1'b0, 1'b0, "rst_after", waited, seen);
    checkOutput("rst_after_latency", waited, 1);

`ifdef BUS_MASTER_TX_PARITY_EN
    // Parity bit values for odd and even populations.
    pushByte(8'h07, 1'b0, "par07_push");
    d = modelQ.pop_front();
    runFrame(d, 1, 1, 1'b0, 1'b0, "par07", waited, seen);
    checkOutput("par07_parity", seen[DW+1], 1);
    pushByte(8'h03, 1'b0, "par03_push");
    d = modelQ.pop_front();
    runFrame(d, 1, 1, 1'b0, 1'b0, "par03", waited, seen);
    checkOutput("par03_parity", seen[DW+1], 0);
`endif

    // Randomised bursts with random ack delays and bus_busy jitter mid-frame.
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(1, 5);
      for (int i = 0; i < m; i++) begin
        pushByte(8'($urandom), 1'b1, $sformatf("rnd%0d_push%0d", r, i));
      end
      bus_busy = 1'b0;
      while (modelQ.size() > 0) begin
        d  = modelQ.pop_front();
        ad = $urandom_range(1, 20);
        runFrame(d, ad, ackOffset(ad), ad > TMO, 1'b1,
                 $sformatf("rnd%0d_%0h", r, d), waited, seen);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
